// File: rtl/csr_controller.sv
// csr_controller: machine-mode CSR file (mie, mtvec, mscratch, mepc, mcause).
// Reads are combinational from addr_i; CSR instruction writes and trap
// captures update on the rising edge of clk_i. Reset is asynchronous, active-low.
// Optional feature: define CSR_MSCRATCH_EN to implement mscratch at 0x340;
// without it, 0x340 behaves as an unmapped address.
module csr_controller (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trap_i,
  input  logic [2:0]  opcode_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] imm_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic [31:0] mie_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtvec_o
);

  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  // Low two funct3 bits select the operation; bit 2 selects the immediate.
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_W    = 2'b01;
  localparam logic [1:0] OP_S    = 2'b10;
  localparam logic [1:0] OP_C    = 2'b11;

  // Read-modify-write combine of the old CSR value with the operand.
  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] operand);
    logic [31:0] res;
    case (op)
      OP_W:    res = operand;
      OP_S:    res = old_val | operand;
      OP_C:    res = old_val & ~operand;
      default: res = old_val;
    endcase
    return res;
  endfunction

  logic [31:0] mie_q,    mie_d;
  logic [31:0] mtvec_q,  mtvec_d;
  logic [31:0] mepc_q,   mepc_d;
  logic [31:0] mcause_q, mcause_d;
`ifdef CSR_MSCRATCH_EN
  logic [31:0] mscratch_q, mscratch_d;
`endif

  logic        op_valid;
  logic [31:0] operand;
  logic [31:0] wdata;
  logic        wr_mie;
  logic        wr_mtvec;
  logic        wr_mepc;
  logic        wr_mcause;
`ifdef CSR_MSCRATCH_EN
  logic        wr_mscratch;
`endif

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    read_data_o = 32'h0;
    case (addr_i)
      ADDR_MIE:      read_data_o = mie_q;
      ADDR_MTVEC:    read_data_o = mtvec_q;
`ifdef CSR_MSCRATCH_EN
      ADDR_MSCRATCH: read_data_o = mscratch_q;
`endif
      ADDR_MEPC:     read_data_o = mepc_q;
      ADDR_MCAUSE:   read_data_o = mcause_q;
      default:       read_data_o = 32'h0;
    endcase
  end

  // Decode the CSR instruction into a write value and per-register strobes.
  always_comb begin
    op_valid  = write_enable_i && (opcode_i[1:0] != OP_NONE);
    operand   = opcode_i[2] ? imm_data_i : rs1_data_i;
    wdata     = csr_apply(opcode_i[1:0], read_data_o, operand);
    wr_mie    = op_valid && (addr_i == ADDR_MIE);
    wr_mtvec  = op_valid && (addr_i == ADDR_MTVEC);
    wr_mepc   = op_valid && (addr_i == ADDR_MEPC);
    wr_mcause = op_valid && (addr_i == ADDR_MCAUSE);
`ifdef CSR_MSCRATCH_EN
    wr_mscratch = op_valid && (addr_i == ADDR_MSCRATCH);
`endif
  end

  // Next-state selection; a trap capture takes priority over an instruction
  // write to mepc/mcause, while writes to other CSRs proceed in parallel.
  always_comb begin
    mie_d    = wr_mie   ? wdata : mie_q;
    mtvec_d  = wr_mtvec ? wdata : mtvec_q;
`ifdef CSR_MSCRATCH_EN
    mscratch_d = wr_mscratch ? wdata : mscratch_q;
`endif
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (trap_i) begin
      mepc_d   = pc_i;
      mcause_d = mcause_i;
    end else begin
      if (wr_mepc)   mepc_d   = wdata;
      if (wr_mcause) mcause_d = wdata;
    end
  end

  // CSR state registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie_q    <= 32'h0;
      mtvec_q  <= 32'h0;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
    end else begin
      mie_q    <= mie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

`ifdef CSR_MSCRATCH_EN
  // Scratch register, only present when the option is enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mscratch_q <= 32'h0;
    else         mscratch_q <= mscratch_d;
  end
`endif

  assign mie_o   = mie_q;
  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_controller.sv
// Scoreboard bench for csr_controller: expectations are queued when stimulus
// is applied and compared once the DUT has taken the clock edge.
module tb_csr_controller;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

  localparam int K_RD = 0, K_MIE = 1, K_MTVEC = 2, K_MEPC = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        trap_i = 1'b0;
  logic [2:0]  opcode_i = 3'b000;
  logic [11:0] addr_i = 12'h000;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] mcause_i = 32'h0;
  logic [31:0] rs1_data_i = 32'h0;
  logic [31:0] imm_data_i = 32'h0;
  logic        write_enable_i = 1'b0;
  logic [31:0] read_data_o, mie_o, mepc_o, mtvec_o;

  csr_controller dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trap_i(trap_i), .opcode_i(opcode_i),
    .addr_i(addr_i), .pc_i(pc_i), .mcause_i(mcause_i), .rs1_data_i(rs1_data_i),
    .imm_data_i(imm_data_i), .write_enable_i(write_enable_i),
    .read_data_o(read_data_o), .mie_o(mie_o), .mepc_o(mepc_o), .mtvec_o(mtvec_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    int          kind;
    logic [11:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_mis = 0;

  // bench-side reference state for the random phase
  logic [31:0] m_mie, m_mtvec, m_mscr, m_mepc, m_mcause;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int kind, input logic [11:0] addr,
                          input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.addr = addr; e.exp = exp;
    sbq.push_back(e);
  endtask

  // Compare every queued expectation against the DUT with no write pending.
  task automatic drain();
    exp_t e;
    write_enable_i = 1'b0;
    trap_i = 1'b0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RD: begin addr_i = e.addr; #1; check_val(e.tag, read_data_o, e.exp); end
        K_MIE:   check_val(e.tag, mie_o, e.exp);
        K_MTVEC: check_val(e.tag, mtvec_o, e.exp);
        default: check_val(e.tag, mepc_o, e.exp);
      endcase
    end
  endtask

  task automatic push_all_zero(input string tag);
    push_exp({tag, "_mie"}, K_MIE, 12'h0, 32'h0);
    push_exp({tag, "_mtvec"}, K_MTVEC, 12'h0, 32'h0);
    push_exp({tag, "_mepc"}, K_MEPC, 12'h0, 32'h0);
    push_exp({tag, "_rd304"}, K_RD, 12'h304, 32'h0);
    push_exp({tag, "_rd305"}, K_RD, 12'h305, 32'h0);
    push_exp({tag, "_rd340"}, K_RD, 12'h340, 32'h0);
    push_exp({tag, "_rd341"}, K_RD, 12'h341, 32'h0);
    push_exp({tag, "_rd342"}, K_RD, 12'h342, 32'h0);
  endtask

  // One CSR instruction across one rising edge (trap_i set by caller if wanted).
  task automatic wr(input logic [2:0] op, input logic [11:0] a,
                    input logic [31:0] rs1, input logic [31:0] imm);
    opcode_i = op; addr_i = a; rs1_data_i = rs1; imm_data_i = imm;
    write_enable_i = 1'b1;
    @(posedge clk_i); #1;
    write_enable_i = 1'b0;
    trap_i = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h304) return m_mie;
    if (a == 12'h305) return m_mtvec;
`ifdef CSR_MSCRATCH_EN
    if (a == 12'h340) return m_mscr;
`endif
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
    return 32'h0;
  endfunction

  initial begin
    logic [2:0]  ops[8];
    logic [11:0] addrs[7];
    logic [2:0]  op;
    logic [11:0] a, ra;
    logic [31:0] rs1, imm, src, oldv, newv, pc, cs;
    logic        tr;

    ops = '{3'b000, RW, RS, RC, 3'b100, RWI, RSI, RCI};
    addrs = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0, 12'h000};

    // ---- reset state, checked while reset is held ----
    #2;
    push_all_zero("reset");
    drain();
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // ---- RW to mtvec ----
    wr(RW, 12'h305, 32'hDEADBEEF, 32'h0);
    push_exp("rw_mtvec_o", K_MTVEC, 12'h0, 32'hDEADBEEF);
    push_exp("rw_mtvec_rd", K_RD, 12'h305, 32'hDEADBEEF);
    drain();

    // ---- RS then RC on mie ----
    wr(RW, 12'h304, 32'h0000_00F0, 32'h0);
    wr(RS, 12'h304, 32'h0000_000F, 32'hFFFF_FFFF);
    push_exp("rs_mie", K_MIE, 12'h0, 32'h0000_00FF);
    drain();
    wr(RC, 12'h304, 32'h0000_0030, 32'hFFFF_FFFF);
    push_exp("rc_mie", K_MIE, 12'h0, 32'h0000_00CF);
    push_exp("rc_mie_rd", K_RD, 12'h304, 32'h0000_00CF);
    drain();

    // ---- immediate forms on mepc (rs1 held at a conflicting value) ----
    wr(RWI, 12'h341, 32'hFFFF_FFFF, 32'h1F);
    push_exp("rwi_mepc", K_MEPC, 12'h0, 32'h1F);
    drain();
    wr(RCI, 12'h341, 32'hFFFF_FFFF, 32'h01);
    push_exp("rci_mepc", K_MEPC, 12'h0, 32'h1E);
    drain();
    wr(RSI, 12'h341, 32'h0, 32'h100);
    push_exp("rsi_mepc", K_MEPC, 12'h0, 32'h11E);
    drain();

    // ---- trap beats a same-cycle write to mcause ----
    trap_i = 1'b1; pc_i = 32'h0000_1000; mcause_i = 32'h8000_000B;
    wr(RW, 12'h342, 32'h5, 32'h0);
    push_exp("trap_mepc", K_MEPC, 12'h0, 32'h0000_1000);
    push_exp("trap_mcause", K_RD, 12'h342, 32'h8000_000B);
    drain();

    // ---- trap with a concurrent write to another CSR ----
    trap_i = 1'b1; pc_i = 32'h0000_2004; mcause_i = 32'h0000_0007;
    wr(RW, 12'h305, 32'h0000_0100, 32'h0);
    push_exp("trapw_mtvec", K_MTVEC, 12'h0, 32'h0000_0100);
    push_exp("trapw_mepc", K_MEPC, 12'h0, 32'h0000_2004);
    push_exp("trapw_mcause", K_RD, 12'h342, 32'h0000_0007);
    drain();

    // ---- no-op opcodes and unmapped address leave state alone ----
    wr(3'b000, 12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(3'b100, 12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(RW, 12'h7C0, 32'h1234_5678, 32'h0);
    push_exp("nop_mie", K_MIE, 12'h0, 32'h0000_00CF);
    push_exp("nop_mtvec", K_MTVEC, 12'h0, 32'h0000_0100);
    push_exp("nop_mepc", K_MEPC, 12'h0, 32'h0000_2004);
    push_exp("nop_mcause", K_RD, 12'h342, 32'h0000_0007);
    push_exp("unmapped_rd", K_RD, 12'h7C0, 32'h0);
    drain();

    // ---- mscratch present or absent depending on build ----
    wr(RW, 12'h340, 32'hCAFE_F00D, 32'h0);
`ifdef CSR_MSCRATCH_EN
    push_exp("mscratch_rd", K_RD, 12'h340, 32'hCAFE_F00D);
`else
    push_exp("mscratch_rd", K_RD, 12'h340, 32'h0);
`endif
    push_exp("mscratch_mie", K_MIE, 12'h0, 32'h0000_00CF);
    drain();

    // ---- asynchronous reset between edges ----
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    push_all_zero("arst");
    drain();
    // write and trap attempted while reset is held
    trap_i = 1'b1; pc_i = 32'h0000_3000; mcause_i = 32'h2;
    wr(RW, 12'h304, 32'hFFFF_FFFF, 32'h0);
    push_all_zero("inrst");
    drain();
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    push_all_zero("postrst");
    drain();
    wr(RW, 12'h304, 32'h0000_00A5, 32'h0);
    push_exp("firstwr_mie", K_MIE, 12'h0, 32'h0000_00A5);
    drain();

    // ---- random phase against the bench reference ----
    m_mie = 32'h0000_00A5; m_mtvec = 32'h0; m_mscr = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
    for (int i = 0; i < 60; i++) begin
      op  = ops[$urandom_range(0, 7)];
      a   = addrs[$urandom_range(0, 6)];
      rs1 = $urandom();
      imm = {27'h0, 5'($urandom())};
      tr  = ($urandom_range(0, 3) == 0);
      pc  = $urandom();
      cs  = $urandom();
      // reference update
      src  = op[2] ? imm : rs1;
      oldv = model_read(a);
      case (op[1:0])
        2'b01:   newv = src;
        2'b10:   newv = oldv | src;
        2'b11:   newv = oldv & ~src;
        default: newv = oldv;
      endcase
      if (op[1:0] != 2'b00) begin
        if (a == 12'h304) m_mie = newv;
        else if (a == 12'h305) m_mtvec = newv;
        else if (a == 12'h340) m_mscr = newv;
        else if (a == 12'h341) m_mepc = newv;
        else if (a == 12'h342) m_mcause = newv;
      end
      if (tr) begin
        m_mepc = pc;
        m_mcause = cs;
      end
      trap_i = tr; pc_i = pc; mcause_i = cs;
      wr(op, a, rs1, imm);
      ra = addrs[$urandom_range(0, 6)];
      push_exp("rnd_mie", K_MIE, 12'h0, m_mie);
      push_exp("rnd_mtvec", K_MTVEC, 12'h0, m_mtvec);
      push_exp("rnd_mepc", K_MEPC, 12'h0, m_mepc);
      push_exp("rnd_mcause", K_RD, 12'h342, m_mcause);
      push_exp("rnd_rd", K_RD, ra, model_read(ra));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/csr_controller.md
CSR_CONTROLLER -- requirements
Module: csr_controller

Interface
REQ-001 The block SHALL have no parameters; widths are fixed (XLEN 32, CSR address 12 bits).
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 trap_i  input  1  trap event strobe.
REQ-005 opcode_i  input  3  CSR operation (funct3 encoding).
REQ-006 addr_i  input  12  CSR address.
REQ-007 pc_i  input  32  PC of the trapping instruction, captured into mepc on trap.
REQ-008 mcause_i  input  32  trap cause, captured into mcause on trap.
REQ-009 rs1_data_i  input  32  register operand for CSRRW/RS/RC.
REQ-010 imm_data_i  input  32  zero-extended immediate operand for CSRRWI/RSI/RCI.
REQ-011 write_enable_i  input  1  CSR instruction write strobe.
REQ-012 read_data_o  output  32  current value of CSR at addr_i.
REQ-013 mie_o  output  32  current mie value.
REQ-014 mepc_o  output  32  current mepc value.
REQ-015 mtvec_o  output  32  current mtvec value.

Function
REQ-016 Registers SHALL be: mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, each 32 bits, all bits writable.
REQ-017 read_data_o SHALL be combinational from addr_i (zero-latency); unmapped address reads 32'h0.
REQ-018 Opcodes SHALL be: RW 3'b001, RS 3'b010, RC 3'b011, RWI 3'b101, RSI 3'b110, RCI 3'b111.
REQ-019 With write_enable_i=1 at a rising edge, the addressed CSR SHALL load: RW rs1; RS rs1|old; RC ~rs1&old; RWI imm; RSI imm|old; RCI ~imm&old; old = read_data_o before the edge.
REQ-020 Opcodes 3'b000 and 3'b100, and writes to unmapped addresses, SHALL change no state.
REQ-021 Written value SHALL be visible on read_data_o and the matching direct output one cycle after the write edge.
REQ-022 With trap_i=1 at a rising edge, mepc SHALL load pc_i and mcause SHALL load mcause_i, independent of write_enable_i and opcode_i.
REQ-023 Trap and a CSR write to mepc or mcause in the same cycle: trap value SHALL win; writes to other CSRs in that cycle SHALL still occur.
REQ-024 mie, mtvec, mscratch SHALL change only on a CSR write addressing them; mepc/mcause only on such a write or on trap.
REQ-025 mie_o, mtvec_o, mepc_o SHALL be direct register outputs, stable otherwise.

Reset
REQ-026 rst_ni=0 SHALL asynchronously clear all five CSRs to 32'h0; all outputs read 0 during reset.
REQ-027 Reset asserted mid-operation SHALL override any concurrent write or trap; first update occurs on the first rising edge after rst_ni rises.

Configuration
REQ-028 Macro CSR_MSCRATCH_EN defined: mscratch implemented per REQ-016/019; undefined: 0x340 reads 32'h0 and writes are ignored (unmapped).

Verification
REQ-029 Reset, then RW addr 0x305 rs1=32'hDEADBEEF -> next cycle mtvec_o=read_data_o=32'hDEADBEEF.
REQ-030 mie=32'h0000_00F0, RS rs1=32'h0000_000F then RC rs1=32'h0000_0030 -> mie_o 32'h0000_00FF then 32'h0000_00CF.
REQ-031 RWI addr 0x341 imm=32'h1F -> mepc_o=32'h1F; RCI imm=32'h01 -> mepc_o=32'h1E.
REQ-032 trap_i=1, pc_i=32'h0000_1000, mcause_i=32'h8000_000B, write_enable_i=1 RW 0x342 rs1=5 -> mepc_o=32'h1000, read 0x342=32'h8000_000B.
REQ-033 write_enable_i=1 with opcode 3'b000 or addr 0x7C0 -> all CSRs unchanged; read 0x7C0=0.
REQ-034 Assert rst_ni=0 asynchronously between edges after nonzero writes -> all outputs 0 immediately, remain 0 until first post-reset write.
